sipo_deserializer: RTL and testbench

Serial-to-parallel receiver. It sits downstream of a serial bit source, such as a chain of D flip-flops or a serializer, that drives one bit per valid cycle. It assembles framed WIDTH-bit words from that stream and presents each word on a registered parallel output with a valid/ready handshake. It reports two error conditions, overrun and frame errors, through sticky flags.

---
 rtl/sipo_deserializer_if.sv | 28 ++
 rtl/sipo_deserializer.sv | 123 ++++++++++++
 tb/tb_sipo_deserializer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/sipo_deserializer_if.sv
// Serial-in / parallel-out bundle for sipo_deserializer.
// master = deserializer side, slave = serial source plus word consumer side.
interface sipo_deserializer_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic             Serial_In;
    logic             Serial_Valid_In;
    logic             Frame_Start_In;
    logic [WIDTH-1:0] Data_Out;
    logic             Data_Valid_Out;
    logic             Data_Ready_In;
    logic [CW-1:0]    Bit_Count_Out;
    logic             Overrun_Out;
    logic             Frame_Err_Out;
    logic             Status_Clear_In;

    modport master (
        input  Serial_In, Serial_Valid_In, Frame_Start_In, Data_Ready_In, Status_Clear_In,
        output Data_Out, Data_Valid_Out, Bit_Count_Out, Overrun_Out, Frame_Err_Out
    );

    modport slave (
        output Serial_In, Serial_Valid_In, Frame_Start_In, Data_Ready_In, Status_Clear_In,
        input  Data_Out, Data_Valid_Out, Bit_Count_Out, Overrun_Out, Frame_Err_Out
    );
endinterface

// File: rtl/sipo_deserializer.sv
// Framed serial-to-parallel receiver with a registered valid/ready word output
// and sticky overrun / frame-error flags.
module sipo_deserializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                Clk_In,
    input  logic                Reset_In,
    sipo_deserializer_if.master Ser_Bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [WIDTH-1:0] w_shift_in;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_nxt;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_data_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_ovr;
    logic             w_ovr_nxt;
    logic             r_ferr;
    logic             w_ferr_nxt;
    logic             w_complete;
    logic             w_ovr_evt;
    logic             w_ferr_evt;

    // A plain shift is enough: by completion every position has been refilled,
    // so stale bits from an aborted or earlier word never reach Data_Out.
    assign w_shift_in = MSB_FIRST ? {r_shift[WIDTH-2:0], Ser_Bus.Serial_In}
                                  : {Ser_Bus.Serial_In, r_shift[WIDTH-1:1]};

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_count_nxt = r_count;
        w_complete  = 1'b0;
        w_ferr_evt  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (Ser_Bus.Serial_Valid_In && Ser_Bus.Frame_Start_In) begin
                    w_shift_nxt = w_shift_in;
                    w_count_nxt = CW'(1);
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (Ser_Bus.Serial_Valid_In) begin
                    w_shift_nxt = w_shift_in;
                    if (Ser_Bus.Frame_Start_In) begin
                        w_ferr_evt  = 1'b1;
                        w_count_nxt = CW'(1);
                    end else if (r_count == CW'(WIDTH - 1)) begin
                        w_complete  = 1'b1;
                        w_count_nxt = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_count_nxt = r_count + CW'(1);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid && !Ser_Bus.Data_Ready_In;
        w_ovr_evt   = 1'b0;
        if (w_complete) begin
            // Output slot is free if empty or being accepted on this same edge.
            if (!r_valid || Ser_Bus.Data_Ready_In) begin
                w_data_nxt  = w_shift_nxt;
                w_valid_nxt = 1'b1;
            end else begin
                w_ovr_evt   = 1'b1;
            end
        end
        w_ovr_nxt  = w_ovr_evt  || (r_ovr  && !Ser_Bus.Status_Clear_In);
        w_ferr_nxt = w_ferr_evt || (r_ferr && !Ser_Bus.Status_Clear_In);
    end

    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_count <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_count <= w_count_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_ovr   <= w_ovr_nxt;
            r_ferr  <= w_ferr_nxt;
        end
    end

    assign Ser_Bus.Data_Out       = r_data;
    assign Ser_Bus.Data_Valid_Out = r_valid;
    assign Ser_Bus.Bit_Count_Out  = r_count;
    assign Ser_Bus.Overrun_Out    = r_ovr;
    assign Ser_Bus.Frame_Err_Out  = r_ferr;

    a_count_range: assert property (@(posedge Clk_In) disable iff (Reset_In)
        r_count < CW'(WIDTH));

    a_hold_word: assert property (@(posedge Clk_In) disable iff (Reset_In)
        (r_valid && !Ser_Bus.Data_Ready_In) |=> (r_valid && $stable(r_data)));
endmodule

// File: tb/tb_sipo_deserializer.sv
// Scoreboard bench for sipo_deserializer: one MSB-first and one LSB-first instance.
module tb_sipo_deserializer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic drv_bit   = 1'b0;
    logic drv_valid = 1'b0;
    logic drv_start = 1'b0;
    logic drv_ready = 1'b0;
    logic drv_clear = 1'b0;
    logic sel       = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    sipo_deserializer_if #(.WIDTH(8)) if0 ();
    sipo_deserializer_if #(.WIDTH(8)) if1 ();

    assign if0.Serial_In       = drv_bit;
    assign if0.Serial_Valid_In = drv_valid && !sel;
    assign if0.Frame_Start_In  = drv_start && !sel;
    assign if0.Data_Ready_In   = drv_ready;
    assign if0.Status_Clear_In = drv_clear;
    assign if1.Serial_In       = drv_bit;
    assign if1.Serial_Valid_In = drv_valid && sel;
    assign if1.Frame_Start_In  = drv_start && sel;
    assign if1.Data_Ready_In   = drv_ready;
    assign if1.Status_Clear_In = drv_clear;

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut_msb (
        .Clk_In(clk), .Reset_In(rst), .Ser_Bus(if0));
    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut_lsb (
        .Clk_In(clk), .Reset_In(rst), .Ser_Bus(if1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: a word is consumed on every edge with valid && ready.
    always @(negedge clk) begin
        if (if0.Data_Valid_Out && if0.Data_Ready_In) begin
            if (q0.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL msb_word: got 0x%0h, expected no word", if0.Data_Out);
            end else begin
                check("msb_word", 32'(if0.Data_Out), 32'(q0.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (if1.Data_Valid_Out && if1.Data_Ready_In) begin
            if (q1.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL lsb_word: got 0x%0h, expected no word", if1.Data_Out);
            end else begin
                check("lsb_word", 32'(if1.Data_Out), 32'(q1.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic fs);
        drv_bit   = b;
        drv_valid = 1'b1;
        drv_start = fs;
        step();
        drv_valid = 1'b0;
        drv_start = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input logic lsb_first);
        for (int i = 0; i < 8; i++)
            send_bit(lsb_first ? w[i] : w[7-i], i == 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] w;
        #1 rst = 1'b1;
        step();
        step();
        check("rst_data",  32'(if0.Data_Out), 32'h0);
        check("rst_valid", 32'(if0.Data_Valid_Out), 32'h0);
        check("rst_count", 32'(if0.Bit_Count_Out), 32'h0);
        check("rst_ovr",   32'(if0.Overrun_Out), 32'h0);
        check("rst_ferr",  32'(if0.Frame_Err_Out), 32'h0);
        check("rst_valid_lsb", 32'(if1.Data_Valid_Out), 32'h0);
        rst = 1'b0;
        step();

        // Basic MSB-first capture with consumer ready.
        drv_ready = 1'b1;
        w = 8'hA5;
        q0.push_back(8'hA5);
        for (int i = 0; i < 4; i++) send_bit(w[7-i], i == 0);
        check("t1_count_mid", 32'(if0.Bit_Count_Out), 32'd4);
        for (int i = 4; i < 8; i++) send_bit(w[7-i], 1'b0);
        check("t1_data",  32'(if0.Data_Out), 32'hA5);
        check("t1_valid", 32'(if0.Data_Valid_Out), 32'h1);
        check("t1_count", 32'(if0.Bit_Count_Out), 32'h0);
        step();
        check("t1_valid_one_cycle", 32'(if0.Data_Valid_Out), 32'h0);

        // LSB-first with a 3-cycle gap after bit 4.
        sel = 1'b1;
        q1.push_back(8'hA5);
        for (int i = 0; i < 4; i++) send_bit(w[i], i == 0);
        for (int g = 0; g < 3; g++) begin
            step();
            check("t2_count_gap", 32'(if1.Bit_Count_Out), 32'd4);
        end
        for (int i = 4; i < 8; i++) send_bit(w[i], 1'b0);
        check("t2_data",  32'(if1.Data_Out), 32'hA5);
        check("t2_valid", 32'(if1.Data_Valid_Out), 32'h1);
        step();
        check("t2_valid_clr", 32'(if1.Data_Valid_Out), 32'h0);
        sel = 1'b0;

        // Backpressure and overrun.
        drv_ready = 1'b0;
        q0.push_back(8'h3C);
        send_word(8'h3C, 1'b0);
        check("t3_data1",  32'(if0.Data_Out), 32'h3C);
        check("t3_valid1", 32'(if0.Data_Valid_Out), 32'h1);
        check("t3_ovr0",   32'(if0.Overrun_Out), 32'h0);
        send_word(8'hC3, 1'b0);
        check("t3_data_kept", 32'(if0.Data_Out), 32'h3C);
        check("t3_valid_kept", 32'(if0.Data_Valid_Out), 32'h1);
        check("t3_ovr",       32'(if0.Overrun_Out), 32'h1);
        drv_ready = 1'b1;
        step();
        drv_ready = 1'b0;
        check("t3_valid_clr", 32'(if0.Data_Valid_Out), 32'h0);
        check("t3_ovr_sticky", 32'(if0.Overrun_Out), 32'h1);
        drv_clear = 1'b1;
        step();
        drv_clear = 1'b0;
        check("t3_ovr_clr", 32'(if0.Overrun_Out), 32'h0);

        // Accept on the same edge as completion.
        q0.push_back(8'h11);
        send_word(8'h11, 1'b0);
        check("t4_data1", 32'(if0.Data_Out), 32'h11);
        w = 8'h22;
        q0.push_back(8'h22);
        for (int i = 0; i < 7; i++) send_bit(w[7-i], i == 0);
        drv_ready = 1'b1;
        send_bit(w[0], 1'b0);
        check("t4_data2", 32'(if0.Data_Out), 32'h22);
        check("t4_valid", 32'(if0.Data_Valid_Out), 32'h1);
        check("t4_no_ovr", 32'(if0.Overrun_Out), 32'h0);
        step();
        check("t4_valid_clr", 32'(if0.Data_Valid_Out), 32'h0);

        // Frame error: restart after 5 bits.
        for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0);
        check("t5_count5", 32'(if0.Bit_Count_Out), 32'd5);
        check("t5_ferr0",  32'(if0.Frame_Err_Out), 32'h0);
        w = 8'hF0;
        q0.push_back(8'hF0);
        send_bit(w[7], 1'b1);
        check("t5_ferr",   32'(if0.Frame_Err_Out), 32'h1);
        check("t5_count1", 32'(if0.Bit_Count_Out), 32'd1);
        for (int i = 1; i < 8; i++) send_bit(w[7-i], 1'b0);
        check("t5_data", 32'(if0.Data_Out), 32'hF0);
        step();
        drv_clear = 1'b1;
        step();
        drv_clear = 1'b0;
        check("t5_ferr_clr", 32'(if0.Frame_Err_Out), 32'h0);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        drv_clear = 1'b1;
        send_bit(1'b1, 1'b1);
        drv_clear = 1'b0;
        check("t5_set_wins", 32'(if0.Frame_Err_Out), 32'h1);

        // Asynchronous reset mid-word.
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        check("t6_count3", 32'(if0.Bit_Count_Out), 32'd3);
        #2 rst = 1'b1;
        #1;
        check("t6_count", 32'(if0.Bit_Count_Out), 32'h0);
        check("t6_data",  32'(if0.Data_Out), 32'h0);
        check("t6_valid", 32'(if0.Data_Valid_Out), 32'h0);
        check("t6_ovr",   32'(if0.Overrun_Out), 32'h0);
        check("t6_ferr",  32'(if0.Frame_Err_Out), 32'h0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        check("t6_ignored_count", 32'(if0.Bit_Count_Out), 32'h0);
        check("t6_ignored_valid", 32'(if0.Data_Valid_Out), 32'h0);

        step();
        check("q0_drained", 32'(q0.size()), 32'h0);
        check("q1_drained", 32'(q1.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
